// File: rtl/sd1001_pkg.sv
// Shared types and defaults for the 1001 stream controller and its detector.
package sd1001_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef logic req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sd1001_moore.sv
// Serial Moore detector for the pattern 1001; out is high in the state entered
// right after the final 1, so overlapping matches are recognised.
module sd1001_moore (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam logic [2:0] S_NONE = 3'd0;
  localparam logic [2:0] S_1    = 3'd1;
  localparam logic [2:0] S_10   = 3'd2;
  localparam logic [2:0] S_100  = 3'd3;
  localparam logic [2:0] S_1001 = 3'd4;

  logic [2:0] state_reg;
  logic [2:0] state_next;

  always_comb begin
    state_next = S_NONE;
    case (state_reg)
      S_NONE: state_next = in ? S_1 : S_NONE;
      S_1:    state_next = in ? S_1 : S_10;
      S_10:   state_next = in ? S_1 : S_100;
      S_100:  state_next = in ? S_1001 : S_NONE;
      // The trailing 1 of a match is the leading 1 of the next one.
      S_1001: state_next = in ? S_1 : S_10;
      default: state_next = S_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_NONE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign out = (state_reg == S_1001);

endmodule

// File: rtl/sd1001_stream_ctrl.sv
// Round-robin front end that feeds two requesters' words through one shared
// 1001 detector and returns the overlapping match count per word.
module sd1001_stream_ctrl
  import sd1001_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [2*W-1:0]   req_data,
  output logic [1:0]       req_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [CNT_W-1:0] resp_count,
  input  logic             resp_ready,
  output logic             busy
);

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_reg;
  state_e           state_next;
  req_id_t          ptr_reg;
  req_id_t          resp_id_reg;
  logic [W-1:0]     word_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] count_reg;

  logic             grant_valid;
  req_id_t          grant_id;
  logic [W-1:0]     grant_word;
  logic             det_clr;
  logic             det_rst;
  logic             det_in;
  logic             det_out;
  logic             count_hit;

  // Pointer holder wins when valid, otherwise the other requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr_reg;
    if (req_valid[ptr_reg]) begin
      grant_valid = 1'b1;
      grant_id    = ptr_reg;
    end else if (req_valid[other_id(ptr_reg)]) begin
      grant_valid = 1'b1;
      grant_id    = other_id(ptr_reg);
    end
  end

  assign grant_word = grant_id ? req_data[W +: W] : req_data[0 +: W];

  always_comb begin
    req_ready = 2'b00;
    if (state_reg == IDLE && grant_valid && !reset) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = CLR;
      CLR:     state_next = SHIFT;
      SHIFT:   if (idx_reg == '0) state_next = DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // det_out lags det_in by one edge: skip the first SHIFT cycle, pick up the
  // last bit's result in DRAIN.
  assign count_hit = det_out &&
                     ((state_reg == SHIFT && idx_reg != IDX_TOP) || state_reg == DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= 1'b0;
      resp_id_reg <= 1'b0;
      word_reg    <= '0;
      idx_reg     <= '0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            word_reg    <= grant_word;
            resp_id_reg <= grant_id;
            count_reg   <= '0;
          end
        end
        CLR: idx_reg <= IDX_TOP;
        SHIFT: if (idx_reg != '0) idx_reg <= idx_reg - 1'b1;
        RESP: if (resp_ready) ptr_reg <= other_id(resp_id_reg);
        default: ;
      endcase
      if (count_hit && count_reg != CNT_MAX) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign det_clr = (state_reg == CLR);
  assign det_rst = reset | det_clr;
  assign det_in  = (state_reg == SHIFT) ? word_reg[idx_reg] : 1'b0;

  sd1001_moore u_det (
    .clk   (clk),
    .reset (det_rst),
    .in    (det_in),
    .out   (det_out)
  );

  assign resp_valid = (state_reg == RESP);
  assign resp_id    = resp_id_reg;
  assign resp_count = count_reg;
  assign busy       = (state_reg != IDLE);

endmodule
